// File: rtl/mouse_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mouse_pkg
//  Description : Shared sprite geometry constants and the loader state type.
//                The RUN state exists only when MOUSE_SPRITE_LOADER_RLE_EN
//                is defined.
//  Revision    : 1.0  initial release
// ============================================================================
package mouse_pkg;

    localparam int SPRITE_W  = 64;
    localparam int SPRITE_H  = 64;
    localparam int RAM_DEPTH = SPRITE_W * SPRITE_H;
    localparam int ADDR_W    = $clog2(RAM_DEPTH);
    localparam int RUN_W     = 8;

`ifdef MOUSE_SPRITE_LOADER_RLE_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_RUN  = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2
    } state_t;
`endif

endpackage
`default_nettype wire

// File: rtl/mouse_sprite_loader_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mouse_sprite_loader_if
//  Description : Pixel stream (valid/ready + run length) and sprite RAM
//                write port. The loader is the slave; the stream source /
//                RAM side is the master.
//  Revision    : 1.0  initial release
// ============================================================================
interface mouse_sprite_loader_if
    import mouse_pkg::*;
#(
    parameter int CD   = 12,
    parameter int ADDR = 12
) ();

    logic             s_valid;
    logic [CD-1:0]    s_data;
    logic [RUN_W-1:0] s_run;
    logic             s_ready;
    logic             we;
    logic [ADDR-1:0]  addr_w;
    logic [CD-1:0]    pixel_in;

    modport master (
        output s_valid, s_data, s_run,
        input  s_ready, we, addr_w, pixel_in
    );

    modport slave (
        input  s_valid, s_data, s_run,
        output s_ready, we, addr_w, pixel_in
    );

endinterface
`default_nettype wire

// File: rtl/mouse_addr_cnt.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mouse_addr_cnt
//  Description : Sprite write-address counter (clear, saturating increment,
//                terminal-count flag) plus run-length down-counter.
//  Revision    : 1.0  initial release
// ============================================================================
module mouse_addr_cnt
    import mouse_pkg::*;
#(
    parameter int ADDR = ADDR_W
) (
    input  wire logic             clk,
    input  wire logic             reset_n,
    input  wire logic             clr_i,
    input  wire logic             inc_i,
    input  wire logic             run_load_i,
    input  wire logic [RUN_W-1:0] run_val_i,
    input  wire logic             run_dec_i,
    output logic [ADDR-1:0]       addr_o,
    output logic                  tc_o,
    output logic                  run_last_o
);

    logic [ADDR-1:0]  cnt_q, cnt_d;
    logic [RUN_W-1:0] run_q, run_d;

    // Next address: clear on a new command, otherwise step once per write
    // and stick at the last address so a second pass can never start.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !tc_o) begin
            cnt_d = cnt_q + ADDR'(1);
        end
    end

    // Remaining repeat writes of the current run.
    always_comb begin
        run_d = run_q;
        if (run_load_i) begin
            run_d = run_val_i;
        end else if (run_dec_i && (run_q != '0)) begin
            run_d = run_q - RUN_W'(1);
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
            run_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    assign addr_o     = cnt_q;
    assign tc_o       = &cnt_q;
    assign run_last_o = (run_q == RUN_W'(1));

endmodule
`default_nettype wire

// File: rtl/mouse_sprite_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mouse_sprite_loader
//  Description : Fills or stream-loads a 64x64 mouse sprite RAM, one write
//                per cycle, with done pulse on the final address and abort.
//                Define MOUSE_SPRITE_LOADER_RLE_EN to expand each stream beat
//                into s_run+1 writes (RUN state).
//  Revision    : 1.0  initial release
// ============================================================================
module mouse_sprite_loader
    import mouse_pkg::*;
#(
    parameter int            CD        = 12,
    parameter int            ADDR      = ADDR_W,
    parameter logic [CD-1:0] KEY_COLOR = '0
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    input  wire logic          cmd_load,
    input  wire logic          cmd_fill,
    input  wire logic          cmd_abort,
    input  wire logic [CD-1:0] fill_color,
    output logic               busy,
    output logic               done,
    mouse_sprite_loader_if.slave bus
);

    state_t          state_q;
    logic            we_q;
    logic            busy_q;
    logic            done_q;
    logic            s_ready_q;
    logic [ADDR-1:0] addr_w_q;
    logic [CD-1:0]   pixel_in_q;
    logic [CD-1:0]   color_q;

    logic [ADDR-1:0] cnt;
    logic            cnt_tc;
    logic            run_last;
    logic            accept;
    logic            start;
    logic            wr_en;
    logic            run_load;
    logic            run_dec;

    // s_ready_q is only ever high in LOAD, so this is a LOAD-state beat.
    assign accept = bus.s_valid & s_ready_q;
    assign start  = (state_q == ST_IDLE) & (cmd_load | cmd_fill);

    // Decide whether this cycle writes RAM; abort suppresses everything.
    always_comb begin
        wr_en    = 1'b0;
        run_load = 1'b0;
        run_dec  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                wr_en = accept;
`ifdef MOUSE_SPRITE_LOADER_RLE_EN
                run_load = accept;
`endif
            end
            ST_FILL: wr_en = 1'b1;
`ifdef MOUSE_SPRITE_LOADER_RLE_EN
            ST_RUN: begin
                wr_en   = 1'b1;
                run_dec = 1'b1;
            end
`endif
            default: ;
        endcase
        if (cmd_abort) begin
            wr_en    = 1'b0;
            run_load = 1'b0;
            run_dec  = 1'b0;
        end
    end

    mouse_addr_cnt #(
        .ADDR (ADDR)
    ) u_cnt (
        .clk        (clk),
        .reset_n    (reset_n),
        .clr_i      (start),
        .inc_i      (wr_en),
        .run_load_i (run_load),
        .run_val_i  (bus.s_run),
        .run_dec_i  (run_dec),
        .addr_o     (cnt),
        .tc_o       (cnt_tc),
        .run_last_o (run_last)
    );

`ifndef MOUSE_SPRITE_LOADER_RLE_EN
    logic unused_run_last;
    assign unused_run_last = run_last;
`endif

    // Control FSM with registered write port, handshake and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_w_q   <= '0;
            pixel_in_q <= '0;
            color_q    <= KEY_COLOR;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            s_ready_q  <= 1'b0;
        end else begin
            we_q   <= 1'b0;
            done_q <= 1'b0;
            if (cmd_abort && (state_q != ST_IDLE)) begin
                state_q   <= ST_IDLE;
                busy_q    <= 1'b0;
                s_ready_q <= 1'b0;
            end else begin
                if (wr_en) begin
                    we_q       <= 1'b1;
                    addr_w_q   <= cnt;
                    pixel_in_q <= (state_q == ST_LOAD) ? bus.s_data : color_q;
                end
                if (wr_en && cnt_tc) begin
                    // Final address written: finish regardless of any run.
                    state_q   <= ST_IDLE;
                    done_q    <= 1'b1;
                    busy_q    <= 1'b0;
                    s_ready_q <= 1'b0;
                end else begin
                    case (state_q)
                        ST_IDLE: begin
                            if (cmd_fill) begin
                                state_q <= ST_FILL;
                                color_q <= fill_color;
                                busy_q  <= 1'b1;
                            end else if (cmd_load) begin
                                state_q   <= ST_LOAD;
                                busy_q    <= 1'b1;
                                s_ready_q <= 1'b1;
                            end
                        end
                        ST_LOAD: begin
`ifdef MOUSE_SPRITE_LOADER_RLE_EN
                            if (accept && (bus.s_run != '0)) begin
                                state_q   <= ST_RUN;
                                color_q   <= bus.s_data;
                                s_ready_q <= 1'b0;
                            end
`endif
                        end
`ifdef MOUSE_SPRITE_LOADER_RLE_EN
                        ST_RUN: begin
                            if (run_last) begin
                                state_q   <= ST_LOAD;
                                s_ready_q <= 1'b1;
                            end
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign bus.s_ready  = s_ready_q;
    assign bus.we       = we_q;
    assign bus.addr_w   = addr_w_q;
    assign bus.pixel_in = pixel_in_q;

endmodule
`default_nettype wire

// File: tb/tb_mouse_sprite_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mouse_sprite_loader
//  Description : Scoreboard bench for mouse_sprite_loader: stimulus pushes
//                expected RAM writes, a negedge monitor pops and compares.
//                Covers MOUSE_SPRITE_LOADER_RLE_EN when defined.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mouse_sprite_loader;
    import mouse_pkg::*;

    localparam int CD    = 12;
    localparam int ADDR  = 12;
    localparam int DEPTH = 4096;
`ifdef MOUSE_SPRITE_LOADER_RLE_EN
    localparam bit RLE = 1'b1;
`else
    localparam bit RLE = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cmd_load, cmd_fill, cmd_abort;
    logic [CD-1:0] fill_color;
    logic          busy, done;

    mouse_sprite_loader_if #(.CD(CD), .ADDR(ADDR)) bus ();

    mouse_sprite_loader #(
        .CD        (CD),
        .ADDR      (ADDR),
        .KEY_COLOR (12'h000)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cmd_load   (cmd_load),
        .cmd_fill   (cmd_fill),
        .cmd_abort  (cmd_abort),
        .fill_color (fill_color),
        .busy       (busy),
        .done       (done),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR-1:0] addr;
        logic [CD-1:0]   data;
        logic            done;
    } wr_t;

    wr_t exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input int a, input logic [CD-1:0] d, input bit dn);
        wr_t e;
        e.addr = a[ADDR-1:0];
        e.data = d;
        e.done = dn;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin : mon
        wr_t e;
        if (reset_n === 1'b1) begin
            if (bus.we === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, expected no write at %0t",
                             bus.addr_w, bus.pixel_in, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wr_addr", 32'(bus.addr_w), 32'(e.addr));
                    chk("wr_data", 32'(bus.pixel_in), 32'(e.data));
                    chk("wr_done", 32'(done), 32'(e.done));
                end
            end else begin
                chk("done_without_we", 32'(done), 32'd0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int i;
        cmd_load = 1'b0; cmd_fill = 1'b0; cmd_abort = 1'b0;
        fill_color = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_run = '0;
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        // Reset state, before any clock edge
        chk("rst_we",       32'(bus.we), 0);
        chk("rst_busy",     32'(busy), 0);
        chk("rst_done",     32'(done), 0);
        chk("rst_s_ready",  32'(bus.s_ready), 0);
        chk("rst_addr_w",   32'(bus.addr_w), 0);
        chk("rst_pixel_in", 32'(bus.pixel_in), 0);
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Full streamed load, s_valid held high
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        chk("load_busy",  32'(busy), 1);
        chk("load_ready", 32'(bus.s_ready), 1);
        bus.s_valid = 1'b1;
        bus.s_data  = 12'h0F0;
        bus.s_run   = RLE ? 8'h00 : 8'h55;
        for (int k = 0; k < DEPTH; k++) begin
            push(k, 12'h0F0, k == DEPTH - 1);
            if (k % 512 == 0) chk("load_ready_hold", 32'(bus.s_ready), 1);
            if (k == DEPTH - 1) chk("busy_before_last", 32'(busy), 1);
            tick();
        end
        bus.s_valid = 1'b0;
        tick();
        chk("busy_after_done",  32'(busy), 0);
        chk("ready_after_done", 32'(bus.s_ready), 0);
        chk("sb_empty_load",    32'(exp_q.size()), 0);

        // Fill with colour held from command time, cmd_load ignored mid-fill
        fill_color = 12'h000;
        cmd_fill = 1'b1; tick(); cmd_fill = 1'b0;
        fill_color = 12'hFFF;
        for (int k = 0; k < DEPTH; k++) push(k, 12'h000, k == DEPTH - 1);
        for (int k = 0; k < DEPTH; k++) begin
            cmd_load = (k == 1000);
            tick();
            chk("fill_we", 32'(bus.we), 1);
        end
        cmd_load = 1'b0;
        tick();
        chk("fill_end_we",   32'(bus.we), 0);
        chk("fill_end_busy", 32'(busy), 0);
        chk("sb_empty_fill", 32'(exp_q.size()), 0);

        // Gapped stream, cmd_fill ignored while busy, abort after 100 beats
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        acc = 0;
        i   = 0;
        while (acc < 100 && i < 1000) begin
            bus.s_valid = (((i * 5) % 7) < 4);
            bus.s_data  = 12'(i * 37 + 3);
            bus.s_run   = RLE ? 8'h00 : 8'(i * 13);
            cmd_fill    = (i == 20);
            fill_color  = 12'h123;
            if (bus.s_valid) begin
                push(acc, bus.s_data, 1'b0);
                acc++;
            end
            tick();
            i++;
        end
        cmd_fill    = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 12'hBAD;
        cmd_abort   = 1'b1;
        tick();
        cmd_abort   = 1'b0;
        bus.s_valid = 1'b0;
        chk("abort_we",    32'(bus.we), 0);
        chk("abort_busy",  32'(busy), 0);
        chk("abort_ready", 32'(bus.s_ready), 0);
        repeat (3) tick();
        chk("sb_empty_abort", 32'(exp_q.size()), 0);

        // New load restarts at address 0
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        bus.s_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            bus.s_data = 12'(12'h700 + k);
            push(k, bus.s_data, 1'b0);
            tick();
        end
        bus.s_valid = 1'b0;
        tick();
        chk("sb_empty_restart", 32'(exp_q.size()), 0);
        cmd_abort = 1'b1; tick(); cmd_abort = 1'b0;
        chk("restart_abort_busy", 32'(busy), 0);

`ifdef MOUSE_SPRITE_LOADER_RLE_EN
        // Run crossing the last address is truncated at 4095
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_run   = 8'h00;
        for (int k = 0; k < 4090; k++) begin
            bus.s_data = 12'(k);
            push(k, bus.s_data, 1'b0);
            tick();
        end
        bus.s_data = 12'hABC;
        bus.s_run  = 8'd9;
        for (int k = 4090; k < DEPTH; k++) push(k, 12'hABC, k == DEPTH - 1);
        tick();
        bus.s_data = 12'h111;
        bus.s_run  = 8'd3;
        for (int k = 0; k < 5; k++) begin
            chk("rle_ready_low", 32'(bus.s_ready), 0);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.s_run   = 8'h00;
        tick();
        chk("rle_busy_end", 32'(busy), 0);
        chk("sb_empty_rle", 32'(exp_q.size()), 0);
`endif

        // Asynchronous reset in the middle of a load
        cmd_load = 1'b1; tick(); cmd_load = 1'b0;
        bus.s_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.s_data = 12'(12'h300 + k);
            push(k, bus.s_data, 1'b0);
            tick();
        end
        #2;
        chk("pre_reset_we", 32'(bus.we), 1);
        reset_n = 1'b0;
        #1;
        chk("async_rst_we",    32'(bus.we), 0);
        chk("async_rst_busy",  32'(busy), 0);
        chk("async_rst_ready", 32'(bus.s_ready), 0);
        chk("async_rst_done",  32'(done), 0);
        exp_q.delete();
        bus.s_valid = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 0);
        chk("post_rst_we",   32'(bus.we), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mouse_sprite_loader.md
MOUSE_SPRITE_LOADER -- requirements
Module: mouse_sprite_loader

Interface
REQ-001 SHALL have parameter CD, default 12, pixel colour depth.
REQ-002 SHALL have parameter ADDR, default 12, sprite RAM address width (64x64 sprite).
REQ-003 SHALL have parameter KEY_COLOR, default 0, chroma key used by clear.
REQ-004 SHALL have port clk  in  1  single clock; all logic rising-edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port cmd_load  in  1  one-cycle pulse; start streamed load at address 0.
REQ-007 SHALL have port cmd_fill  in  1  one-cycle pulse; start fill of all entries with fill_color.
REQ-008 SHALL have port cmd_abort  in  1  one-cycle pulse; terminate any operation.
REQ-009 SHALL have port fill_color  in  CD  colour for fill (use KEY_COLOR to clear the sprite).
REQ-010 SHALL have port s_valid  in  1  pixel stream valid.
REQ-011 SHALL have port s_data  in  CD  pixel stream colour.
REQ-012 SHALL have port s_run  in  8  run length minus 1 (used only with RLE).
REQ-013 SHALL have port s_ready  out  1  stream ready.
REQ-014 SHALL have ports we / addr_w / pixel_in  out  1 / ADDR / CD  sprite RAM write port.
REQ-015 SHALL have port busy  out  1  operation in progress.
REQ-016 SHALL have port done  out  1  one-cycle pulse on normal completion.

Function
REQ-017 SHALL implement states IDLE, LOAD, FILL, plus RUN when RLE is compiled in.
REQ-018 IDLE: cmd_fill -> FILL, else cmd_load -> LOAD; both asserted together -> FILL; address counter cleared to 0.
REQ-019 cmd_load/cmd_fill SHALL be ignored while busy=1.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 s_ready SHALL be 1 only in LOAD.
REQ-022 A beat is accepted when s_valid & s_ready; data/valid SHALL NOT be required to stay stable while s_ready=0.
REQ-023 Each accepted beat (no RLE) SHALL produce one write: we=1, addr_w=counter, pixel_in=s_data, registered, on the next edge (latency 1 cycle).
REQ-024 FILL SHALL write fill_color (sampled at command, held) to one address per cycle, no handshake; total 2^ADDR cycles.
REQ-025 Counter SHALL increment by 1 after each write; the write to address 2^ADDR-1 is last: next state IDLE, done=1 coincident with that write's we.
REQ-026 Counter SHALL never wrap into a second pass; no write occurs beyond 2^ADDR-1.
REQ-027 cmd_abort SHALL have priority over all other inputs: next state IDLE, no further writes after the edge, done stays 0; abort in IDLE has no effect.
REQ-028 we SHALL be 0 in any cycle with no write; addr_w/pixel_in hold their last values when we=0.

Reset
REQ-029 reset_n low SHALL asynchronously force IDLE, counter 0, we=0, addr_w=0, pixel_in=0, busy=0, done=0, s_ready=0.
REQ-030 Reset mid-operation SHALL abandon it with no done pulse; RAM contents are not restored.

Configuration
REQ-031 Macro MOUSE_SPRITE_LOADER_RLE_EN defined: each accepted beat in LOAD SHALL write s_data to s_run+1 consecutive addresses, one per cycle; state RUN holds s_ready=0 until the run ends, then returns to LOAD.
REQ-032 A run crossing 2^ADDR-1 SHALL be truncated at that address; completion per REQ-025.
REQ-033 Macro undefined: s_run SHALL be ignored, state RUN absent, one write per beat.

Structure
REQ-034 The state enumeration typedef and the sprite size constants (64x64, RAM depth) SHALL reside in a shared package mouse_pkg.
REQ-035 The address/run counter SHALL be a sub-module mouse_addr_cnt (load-zero, increment, terminal-count flag, run down-counter).

Verification
REQ-036 Reset, cmd_load, 4096 beats of colour 12'h0F0 with s_valid held 1 -> 4096 writes, addr 0..4095 in order, done once coincident with addr 4095, busy falls the next cycle.
REQ-037 cmd_fill with fill_color=12'h000 -> 4096 consecutive we cycles, all pixel_in=0; cmd_load pulsed mid-fill is ignored.
REQ-038 LOAD with randomly gapped s_valid -> write count equals accepted beats; no write in idle gaps.
REQ-039 cmd_abort after 100 beats -> writes stop at addr 99, done=0; a new cmd_load restarts at addr 0.
REQ-040 RLE_EN: beat (s_data=12'hABC, s_run=9) at addr 4090 -> writes 4090..4095, s_ready=0 during the run, done at 4095.
REQ-041 reset_n asserted mid-LOAD asynchronously -> we=0 and busy=0 before the next clk edge.
